// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX word FIFOs. SPI pins are oversampled on Clk through
// synchronisers. Mode and bit order are captured once per frame.

// Synchronous FIFO used for both the TX and RX word paths.
module SpiSlaveFifoBuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstN_i,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdEn_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;

  assign empty_o  = (wrPtr_q == rdPtr_q);
  assign full_o   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdData_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  // Storage array; the caller only asserts wrEn_i when a slot is free
  // (or is being freed by a read in the same cycle).
  always_ff @(posedge clk_i) begin
    if (wrEn_i) mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
  end

  // Next pointer values.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (wrEn_i) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (rdEn_i) rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end
endmodule

module spi_slave_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [1:0]            MODE,
  input  logic                  LSB_FIRST,
  input  logic [DATA_WIDTH-1:0] TxData,
  input  logic                  TxValid,
  output logic                  TxReady,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  RxValid,
  input  logic                  RxReady,
  output logic                  Busy,
  output logic                  RxOverflow,
  output logic                  TxUnderrun,
  output logic                  FrameAbort,
  input  logic                  ErrClr,
  input  logic                  SClk,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rstSync_q;
  logic                  rstInt_n;
  logic [SYNC_STAGES-1:0] sclkSync_q, mosiSync_q, ssSync_q;
  logic                  sclkS, mosiS, ssS;
  logic                  sclkPrev_q, ssPrev_q;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [CW-1:0]         bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] rxShift_q, rxShift_d, txShift_q, txShift_d;
  logic [DATA_WIDTH-1:0] rxAssembled, txShifted, txHead;
  logic                  rxOverflow_q, rxOverflow_d, txUnderrun_q, txUnderrun_d;
  logic                  frameAbort_q, frameAbort_d;
  logic                  ssFall, inXfer, leadEdge, trailEdge, sampleEdge, shiftEdge, lastBit;
  logic                  loadTx, rxPushReq, abortSet, underrunSet, overflowSet;
  logic                  txWr, txPop, txFull, txEmpty, rxPush, rxPop, rxFull, rxEmpty;
  logic                  misoBit;

  // Reset asserts immediately but is released only on a Clk edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rstSync_q <= '0;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end
  assign rstInt_n = rstSync_q[1];

  // Pin synchronisers; reset to 0 so an SS already low at release is not a falling edge.
  always_ff @(posedge Clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      sclkSync_q <= '0;
      mosiSync_q <= '0;
      ssSync_q   <= '0;
      sclkPrev_q <= 1'b0;
      ssPrev_q   <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SClk};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], MOSI};
      ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], SS};
      sclkPrev_q <= sclkS;
      ssPrev_q   <= ssS;
    end
  end

  assign sclkS = sclkSync_q[SYNC_STAGES-1];
  assign mosiS = mosiSync_q[SYNC_STAGES-1];
  assign ssS   = ssSync_q[SYNC_STAGES-1];

  assign ssFall     = ssPrev_q & ~ssS;
  assign inXfer     = (state_q == XFER) && !ssS;
  assign leadEdge   = inXfer && (sclkPrev_q == cpol_q) && (sclkS != cpol_q);
  assign trailEdge  = inXfer && (sclkPrev_q != cpol_q) && (sclkS == cpol_q);
  assign sampleEdge = cpha_q ? trailEdge : leadEdge;
  assign shiftEdge  = cpha_q ? leadEdge : trailEdge;
  assign lastBit    = (bitCnt_q == CW'(DATA_WIDTH-1));

  assign rxAssembled = lsb_q ? {mosiS, rxShift_q[DATA_WIDTH-1:1]}
                             : {rxShift_q[DATA_WIDTH-2:0], mosiS};
  assign txShifted   = lsb_q ? {1'b0, txShift_q[DATA_WIDTH-1:1]}
                             : {txShift_q[DATA_WIDTH-2:0], 1'b0};

  // Frame sequencing: a falling SS starts a frame, SS high always ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssFall) state_d = LOAD;
      LOAD:    state_d = ssS ? IDLE : XFER;
      XFER:    if (ssS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge rstInt_n) begin
    if (!rstInt_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Shift registers, bit counter, mode capture and word load/push requests.
  always_comb begin
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    loadTx    = 1'b0;
    rxPushReq = 1'b0;
    abortSet  = 1'b0;
    if (state_q == IDLE && ssFall) begin
      cpol_d = MODE[1];
      cpha_d = MODE[0];
      lsb_d  = LSB_FIRST;
    end
    if (state_q == LOAD) begin
      loadTx    = 1'b1;
      bitCnt_d  = '0;
      rxShift_d = '0;
    end
    if (state_q == XFER) begin
      if (ssS) begin
        abortSet = (bitCnt_q != '0);
        bitCnt_d = '0;
      end else begin
        if (sampleEdge) begin
          rxShift_d = rxAssembled;
          if (lastBit) begin
            bitCnt_d  = '0;
            rxPushReq = 1'b1;
            if (cpha_q) loadTx = 1'b1;
          end else begin
            bitCnt_d = bitCnt_q + CW'(1);
          end
        end
        if (shiftEdge) begin
          if (bitCnt_q != '0) txShift_d = txShifted;
          else if (!cpha_q)   loadTx    = 1'b1;
        end
      end
    end
    if (loadTx) txShift_d = txEmpty ? '0 : txHead;
  end

  assign txWr        = TxValid && !txFull;
  assign txPop       = loadTx && !txEmpty;
  assign underrunSet = loadTx && txEmpty;
  assign rxPop       = RxReady && !rxEmpty;
  assign overflowSet = rxPushReq && rxFull && !rxPop;
  assign rxPush      = rxPushReq && !overflowSet;

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_comb begin
    rxOverflow_d = overflowSet | (rxOverflow_q & ~ErrClr);
    txUnderrun_d = underrunSet | (txUnderrun_q & ~ErrClr);
    frameAbort_d = abortSet    | (frameAbort_q & ~ErrClr);
  end

  // Datapath and flag registers.
  always_ff @(posedge Clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      bitCnt_q     <= '0;
      rxShift_q    <= '0;
      txShift_q    <= '0;
      rxOverflow_q <= 1'b0;
      txUnderrun_q <= 1'b0;
      frameAbort_q <= 1'b0;
    end else begin
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      lsb_q        <= lsb_d;
      bitCnt_q     <= bitCnt_d;
      rxShift_q    <= rxShift_d;
      txShift_q    <= txShift_d;
      rxOverflow_q <= rxOverflow_d;
      txUnderrun_q <= txUnderrun_d;
      frameAbort_q <= frameAbort_d;
    end
  end

  SpiSlaveFifoBuf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk_i(Clk), .rstN_i(rstInt_n), .wrEn_i(txWr), .wrData_i(TxData),
    .rdEn_i(txPop), .rdData_o(txHead), .full_o(txFull), .empty_o(txEmpty)
  );

  SpiSlaveFifoBuf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk_i(Clk), .rstN_i(rstInt_n), .wrEn_i(rxPush), .wrData_i(rxAssembled),
    .rdEn_i(rxPop), .rdData_o(RxData), .full_o(rxFull), .empty_o(rxEmpty)
  );

  assign misoBit    = lsb_q ? txShift_q[0] : txShift_q[DATA_WIDTH-1];
  assign MISO       = (state_q != IDLE) ? misoBit : 1'bz;
  assign Busy       = (state_q != IDLE) && !ssS;
  assign TxReady    = !txFull;
  assign RxValid    = !rxEmpty;
  assign RxOverflow = rxOverflow_q;
  assign TxUnderrun = txUnderrun_q;
  assign FrameAbort = frameAbort_q;
endmodule

// File: doc/spi_slave_fifo.md
SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI word (legal 4..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per TX and RX FIFO (power of 2, >=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on SClk/MOSI/SS (>=2).
REQ-004 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port MODE  input  2  SPI mode {CPOL,CPHA}.
REQ-007 SHALL have port LSB_FIRST  input  1  1 = LSB shifted first, 0 = MSB first.
REQ-008 SHALL have ports TxData input DATA_WIDTH, TxValid input 1, TxReady output 1: TX FIFO write, valid/ready handshake.
REQ-009 SHALL have ports RxData output DATA_WIDTH, RxValid output 1, RxReady input 1: RX FIFO read, valid/ready handshake.
REQ-010 SHALL have port Busy  output 1  SS asserted (synchronised) and frame in progress.
REQ-011 SHALL have ports RxOverflow, TxUnderrun, FrameAbort  output 1 each  sticky error flags; ErrClr  input 1  clears all three.
REQ-012 SHALL have ports SClk input 1, MOSI input 1, SS input 1 (active-low select), MISO output 1 (high-Z while SS high).

Function
REQ-013 SHALL pass SClk, MOSI, SS through SYNC_STAGES flops; all decisions use synchronised copies; SClk high and low phases are each >= 3 Clk periods.
REQ-014 SHALL latch MODE and LSB_FIRST on synchronised SS falling edge; changes during a frame have no effect until next frame.
REQ-015 SHALL define leading edge = SClk leaving CPOL level, trailing edge = return to it; sample edge = leading if CPHA=0 else trailing; shift edge = the other.
REQ-016 SHALL implement FSM IDLE -> LOAD (SS falls, one cycle) -> XFER; XFER -> IDLE on SS rise; any state -> IDLE on SS high.
REQ-017 SHALL in LOAD pop TX FIFO head into shift register if non-empty, else load all-zeros and set TxUnderrun.
REQ-018 SHALL drive MISO from shift register MSB (LSB when LSB_FIRST) combinationally from the register, so bit 0 of the word is valid before the first leading edge for CPHA=0.
REQ-019 SHALL on each sample edge shift MOSI into RX shift register (MSB- or LSB-first per latched mode) and increment a bit counter 0..DATA_WIDTH-1.
REQ-020 SHALL on each shift edge advance the TX shift register, except: CPHA=1 first leading edge of each word (no shift); word-boundary shift edge (CPHA=0) loads the next word instead.
REQ-021 SHALL on the DATA_WIDTH-th sample edge push the assembled word to RX FIFO (visible on RxValid the next Clk cycle) and wrap the bit counter to 0.
REQ-022 SHALL for CPHA=1 load next TX word at the DATA_WIDTH-th sample edge; for CPHA=0 at the following trailing edge; empty TX FIFO loads zeros and sets TxUnderrun.
REQ-023 SHALL when RX FIFO is full at push time drop the new word and set RxOverflow; push and pop on the same cycle with full FIFO both succeed.
REQ-024 SHALL on SS rise with bit counter != 0 discard the partial word, set FrameAbort, and not return the unconsumed TX word to the FIFO.
REQ-025 SHALL set TxReady = TX FIFO not full; RxValid = RX FIFO not empty; RxData = RX FIFO head; simultaneous TX write and pop both succeed.
REQ-026 SHALL give error set priority over ErrClr in the same cycle.

Reset
REQ-027 SHALL on Rst_n low: FSM IDLE, FIFOs empty, counters 0, TxReady=1, RxValid=0, RxData=0, Busy=0, all error flags 0, MISO high-Z.
REQ-028 SHALL release reset synchronously to Clk; a frame already in progress at release is ignored until SS next rises and falls.

Verification
REQ-029 SHALL cover mode 0, DATA_WIDTH=8: push 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RxData=0x3C, RxValid=1.
REQ-030 SHALL cover all four modes x LSB_FIRST, 3-word frame 0x01,0x80,0xFF both directions -> exact echo in each mode.
REQ-031 SHALL cover TX FIFO empty at LOAD -> MISO all zeros, TxUnderrun=1 until ErrClr pulse.
REQ-032 SHALL cover RxReady=0, FIFO_DEPTH+1 words received -> first 4 words retained in order, 5th dropped, RxOverflow=1.
REQ-033 SHALL cover SS rise after 5 of 8 bits -> no RX push, FrameAbort=1, next frame correct from bit 0.
REQ-034 SHALL cover Rst_n asserted mid-word -> all outputs at reset values within the same cycle, MISO high-Z.
